pwm_monitor: RTL and testbench
==============================

# pwm_monitor

Measures the PWM waveform produced by the PWM generator stage and reports, per PWM period, the high time and period length in clock cycles. It sits directly downstream of the generator on the same 100 MHz clock and feeds measurement results to status and control logic. It also flags a PWM line that stops toggling (stuck high or stuck low).

## Interface
- CNT_W, 8: width of the measurement counters and outputs.
- TIMEOUT, 64: consecutive equal samples that declare the line stuck. Legal range is 2 ≤ TIMEOUT and 2·TIMEOUT ≤ 2^CNT_W − 1; this range guarantees the accumulators never overflow.

- clk  in  1  system clock, 100 MHz; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  monitor enable; 0 forces IDLE.
- pwm_in  in  1  PWM line; same clock domain, so no synchronizer is used.
- high_cnt  out  CNT_W  high cycles of the last complete period.
- period_cnt  out  CNT_W  total cycles of the last complete period.
- meas_valid  out  1  one-cycle pulse when high_cnt/period_cnt update.
- stuck_high  out  1  line held high for TIMEOUT samples.
- stuck_low  out  1  line held low for TIMEOUT samples.

## Operation
- Sampling:
  - pwm_d registers pwm_in every cycle regardless of en; its reset value is 0.
  - A rise is pwm_in=1 while pwm_d=0; a fall is pwm_in=0 while pwm_d=1.
- Internal counters: hi_acc, per_acc and run_cnt, each CNT_W wide.
- run_cnt:
  - Holds 0 while en=0.
  - On an enabled sample it is set to 1 when pwm_in≠pwm_d or on the first enabled sample; otherwise it increments.
- States: IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW.
- IDLE:
  - Entered when en=0, from any state.
  - Clears the accumulators and both stuck flags.
  - High_cnt and period_cnt hold their last values.
  - Moves to WAIT_RISE on the first sample with en=1.
- WAIT_RISE:
  - Discards any partial period.
  - On a rise: hi_acc=1, per_acc=1, both stuck flags cleared, go to MEAS_HIGH.
- MEAS_HIGH:
  - While pwm_in=1, hi_acc and per_acc each increment.
  - On a fall: per_acc increments and the state moves to MEAS_LOW.
- MEAS_LOW:
  - While pwm_in=0, per_acc increments.
  - On a rise:
    - high_cnt←hi_acc and period_cnt←per_acc (values before this edge's update); meas_valid=1.
    - hi_acc=1, per_acc=1; go to MEAS_HIGH.
- Timeout:
  - Trigger: the sample that makes run_cnt reach TIMEOUT, in any enabled state.
  - stuck_high (pwm_in=1) or stuck_low (pwm_in=0) is set; state goes to WAIT_RISE; no meas_valid is issued.
  - The flag stays set until the next rise or until en=0.
  - stuck_high and stuck_low are never both 1.
- A rise and a timeout cannot coincide, because a rise reloads run_cnt to 1.
- high_cnt ≥ 1 and period_cnt ≥ 2 for every reported measurement.

## Timing
- Reset: state IDLE; pwm_d, accumulators, run_cnt, high_cnt, period_cnt, meas_valid, stuck_high and stuck_low all 0.
- Measurement latency:
  - Results and meas_valid appear on the clock edge that samples the rise ending the period.
  - meas_valid is high for exactly one cycle.
- The first report after en rises requires one full period after the first observed rise, so the earliest meas_valid is at the second rise.
- A rise already high at enable does not count; pwm_d=1 in that case.
- en deassertion mid-period:
  - Takes effect at the next edge: state goes to IDLE with no meas_valid.
  - The partial period is lost and the outputs retain the previous measurement.
- Asynchronous reset mid-measurement clears everything immediately; after release, operation restarts from IDLE.
- Continuous periodic input yields one meas_valid per period, spaced period_cnt cycles apart.

## Test plan
- Reset and enable, drive 3 high / 7 low repeating -> meas_valid pulses every 10 cycles starting at the second rise; high_cnt=3, period_cnt=10.
- Change the waveform to 1 high / 9 low mid-stream -> the first period fully at the new shape reports 1/10; no spurious pulse at the transition.
- Hold pwm_in=0 for 64 enabled cycles with TIMEOUT=64 -> stuck_low=1 on the 64th sample and state WAIT_RISE; the next 2 high / 2 low pattern clears it at the rise, and the next rise reports 2/4.
- Hold pwm_in=1 for 64 cycles during MEAS_HIGH -> stuck_high=1 with no meas_valid; the flag clears on the next rise.
- Drop en halfway through a 3/10 period -> no meas_valid, high_cnt/period_cnt hold 3/10, flags 0; re-enabling gives the first new report at the second rise.
- Assert reset mid-period while stuck_low=1 -> all outputs 0 immediately; normal 5/10 measurement resumes after release and enable.

Source files
------------

// File: rtl/pwm_monitor_if.sv
// pwm_monitor_if: groups the monitor's enable/input and measurement outputs.
//   master : drives en, pwm_in; observes measurement and stuck flags
//   slave  : the monitor itself
interface pwm_monitor_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             pwm_in;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             meas_valid;
  logic             stuck_high;
  logic             stuck_low;

  modport master (
    output en, pwm_in,
    input  high_cnt, period_cnt, meas_valid, stuck_high, stuck_low
  );

  modport slave (
    input  en, pwm_in,
    output high_cnt, period_cnt, meas_valid, stuck_high, stuck_low
  );
endinterface

// File: rtl/pwm_monitor.sv
// pwm_monitor: measures high time and period length (in clk cycles) of each
// complete PWM period and flags a line that stops toggling.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : pwm_monitor_if.slave
//             en, pwm_in                      -> inputs
//             high_cnt, period_cnt, meas_valid -> last complete period + pulse
//             stuck_high, stuck_low            -> line static for TIMEOUT samples
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | disabled; accumulators and stuck flags cleared, results held
// WAIT_RISE | enabled, waiting for a rise to start a fresh period
// MEAS_HIGH | counting the high phase of the current period
// MEAS_LOW  | counting the low phase; next rise closes and reports the period
module pwm_monitor #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  pwm_monitor_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] TMO_VAL  = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic             pwm_dly_q, pwm_dly_d;
  logic [CNT_W-1:0] hi_acc_q, hi_acc_d;
  logic [CNT_W-1:0] per_acc_q, per_acc_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic             meas_valid_q, meas_valid_d;
  logic             stuck_high_q, stuck_high_d;
  logic             stuck_low_q, stuck_low_d;

  logic rise, fall, timeout;

  assign rise = bus.pwm_in & ~pwm_dly_q;
  assign fall = ~bus.pwm_in & pwm_dly_q;

  always_comb begin
    state_d      = state_q;
    pwm_dly_d    = bus.pwm_in;
    hi_acc_d     = hi_acc_q;
    per_acc_d    = per_acc_q;
    run_cnt_d    = run_cnt_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    meas_valid_d = 1'b0;
    stuck_high_d = stuck_high_q;
    stuck_low_d  = stuck_low_q;
    timeout      = 1'b0;

    if (!bus.en) begin
      state_d      = IDLE;
      hi_acc_d     = CNT_ZERO;
      per_acc_d    = CNT_ZERO;
      run_cnt_d    = CNT_ZERO;
      stuck_high_d = 1'b0;
      stuck_low_d  = 1'b0;
    end else begin
      // Run length of identical samples; the first enabled sample starts a run.
      if (state_q == IDLE || bus.pwm_in != pwm_dly_q) run_cnt_d = CNT_ONE;
      else                                            run_cnt_d = run_cnt_q + CNT_ONE;
      timeout = (run_cnt_d == TMO_VAL);

      case (state_q)
        IDLE: begin
          // A level already high at enable is not a rise, so just arm.
          state_d = WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise) begin
            hi_acc_d     = CNT_ONE;
            per_acc_d    = CNT_ONE;
            stuck_high_d = 1'b0;
            stuck_low_d  = 1'b0;
            state_d      = MEAS_HIGH;
          end
        end
        MEAS_HIGH: begin
          per_acc_d = per_acc_q + CNT_ONE;
          if (fall) state_d  = MEAS_LOW;
          else      hi_acc_d = hi_acc_q + CNT_ONE;
        end
        MEAS_LOW: begin
          if (rise) begin
            high_cnt_d   = hi_acc_q;
            period_cnt_d = per_acc_q;
            meas_valid_d = 1'b1;
            hi_acc_d     = CNT_ONE;
            per_acc_d    = CNT_ONE;
            stuck_high_d = 1'b0;
            stuck_low_d  = 1'b0;
            state_d      = MEAS_HIGH;
          end else begin
            per_acc_d = per_acc_q + CNT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase

      // A rise reloads the run to 1, so this never overrides a report.
      if (timeout) begin
        stuck_high_d = bus.pwm_in;
        stuck_low_d  = ~bus.pwm_in;
        state_d      = WAIT_RISE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pwm_dly_q    <= 1'b0;
      hi_acc_q     <= CNT_ZERO;
      per_acc_q    <= CNT_ZERO;
      run_cnt_q    <= CNT_ZERO;
      high_cnt_q   <= CNT_ZERO;
      period_cnt_q <= CNT_ZERO;
      meas_valid_q <= 1'b0;
      stuck_high_q <= 1'b0;
      stuck_low_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pwm_dly_q    <= pwm_dly_d;
      hi_acc_q     <= hi_acc_d;
      per_acc_q    <= per_acc_d;
      run_cnt_q    <= run_cnt_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      meas_valid_q <= meas_valid_d;
      stuck_high_q <= stuck_high_d;
      stuck_low_q  <= stuck_low_d;
    end
  end

  assign bus.high_cnt   = high_cnt_q;
  assign bus.period_cnt = period_cnt_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.stuck_high = stuck_high_q;
  assign bus.stuck_low  = stuck_low_q;

endmodule

// File: tb/tb_pwm_monitor.sv
// tb_pwm_monitor: directed scenarios with literal expectations plus a
// randomized waveform phase, all checked every cycle against a period-level
// reference model of the monitor.
module tb_pwm_monitor;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 64;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pwm_monitor_if #(.CNT_W(CNT_W)) bus ();

  pwm_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: tracks the period since the last counted rise.
  bit m_prev, m_first, m_anchor, m_seen_fall;
  int m_run, m_hi, m_per;
  int m_high_cnt, m_period_cnt;
  bit m_valid, m_sh, m_sl;

  function automatic void model_clear();
    m_prev = 0; m_first = 1; m_anchor = 0; m_seen_fall = 0;
    m_run = 0; m_hi = 0; m_per = 0;
    m_high_cnt = 0; m_period_cnt = 0;
    m_valid = 0; m_sh = 0; m_sl = 0;
  endfunction

  function automatic void model_step();
    bit rise, fall;
    if (!reset) begin
      model_clear();
      return;
    end
    m_valid = 0;
    if (!bus.en) begin
      m_run = 0; m_anchor = 0; m_sh = 0; m_sl = 0; m_first = 1;
    end else begin
      rise  = bus.pwm_in && !m_prev;
      fall  = !bus.pwm_in && m_prev;
      m_run = (m_first || bus.pwm_in != m_prev) ? 1 : (m_run + 1) % 256;
      if (m_first) begin
        m_anchor = 0;
      end else if (rise) begin
        if (m_anchor && m_seen_fall) begin
          m_high_cnt   = m_hi;
          m_period_cnt = m_per;
          m_valid      = 1;
        end
        m_anchor = 1; m_hi = 1; m_per = 1; m_seen_fall = 0;
        m_sh = 0; m_sl = 0;
      end else if (m_anchor) begin
        m_per = m_per + 1;
        if (bus.pwm_in) m_hi = m_hi + 1;
        if (fall) m_seen_fall = 1;
      end
      if (m_run == TIMEOUT) begin
        m_sh = bus.pwm_in; m_sl = !bus.pwm_in; m_anchor = 0;
      end
      m_first = 0;
    end
    m_prev = bus.pwm_in;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      n_checks++;
      if (bus.high_cnt !== m_high_cnt[CNT_W-1:0] || bus.period_cnt !== m_period_cnt[CNT_W-1:0] ||
          bus.meas_valid !== m_valid || bus.stuck_high !== m_sh || bus.stuck_low !== m_sl) begin
        n_fail++;
        $display("FAIL cycle_model: got hi=%0d per=%0d v=%0d sh=%0d sl=%0d expected hi=%0d per=%0d v=%0d sh=%0d sl=%0d at %0t",
                 bus.high_cnt, bus.period_cnt, bus.meas_valid, bus.stuck_high, bus.stuck_low,
                 m_high_cnt, m_period_cnt, m_valid, m_sh, m_sl, $time);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic step(input bit e, input bit p);
    @(negedge clk);
    bus.en = e;
    bus.pwm_in = p;
    @(posedge clk);
    #2;
  endtask

  // One period of h high / l low samples; checks at the opening rise.
  task automatic period_chk(input string tag, input int h, input int l,
                            input bit exp_v, input int exp_hi, input int exp_per);
    for (int i = 0; i < h + l; i++) begin
      step(1'b1, i < h);
      if (i == 0) begin
        check({tag, "_valid"}, bus.meas_valid, exp_v);
        check({tag, "_sh"}, bus.stuck_high, 0);
        check({tag, "_sl"}, bus.stuck_low, 0);
        if (exp_v) begin
          check({tag, "_high"}, bus.high_cnt, exp_hi);
          check({tag, "_period"}, bus.period_cnt, exp_per);
          check({tag, "_model_high"}, m_high_cnt, exp_hi);
          check({tag, "_model_period"}, m_period_cnt, exp_per);
        end
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_high"}, bus.high_cnt, 0);
    check({tag, "_period"}, bus.period_cnt, 0);
    check({tag, "_valid"}, bus.meas_valid, 0);
    check({tag, "_sh"}, bus.stuck_high, 0);
    check({tag, "_sl"}, bus.stuck_low, 0);
  endtask

  initial begin
    int r, h, l, n;
    bus.en = 1'b0;
    bus.pwm_in = 1'b0;
    model_clear();
    #12;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // 3 high / 7 low
    step(1, 0); step(1, 0);
    period_chk("p37_first", 3, 7, 0, 0, 0);
    for (int k = 0; k < 3; k++) period_chk("p37", 3, 7, 1, 3, 10);

    // switch to 1 high / 9 low
    period_chk("p19_switch", 1, 9, 1, 3, 10);
    period_chk("p19", 1, 9, 1, 1, 10);
    period_chk("p19b", 1, 9, 1, 1, 10);

    // stuck low from enable
    step(0, 0);
    for (int i = 1; i <= TIMEOUT; i++) begin
      step(1, 0);
      if (i == TIMEOUT - 1) check("stuck_low_early", bus.stuck_low, 0);
    end
    check("stuck_low_set", bus.stuck_low, 1);
    check("stuck_low_sh", bus.stuck_high, 0);
    check("stuck_low_model", m_sl, 1);
    period_chk("p22_clear", 2, 2, 0, 0, 0);
    period_chk("p22", 2, 2, 1, 2, 4);
    period_chk("p22b", 2, 2, 1, 2, 4);

    // stuck high during MEAS_HIGH
    step(1, 1);
    check("sh_rise_valid", bus.meas_valid, 1);
    check("sh_rise_period", bus.period_cnt, 4);
    repeat (TIMEOUT - 2) step(1, 1);
    check("stuck_high_early", bus.stuck_high, 0);
    step(1, 1);
    check("stuck_high_set", bus.stuck_high, 1);
    check("stuck_high_valid", bus.meas_valid, 0);
    check("stuck_high_sl", bus.stuck_low, 0);
    repeat (3) step(1, 0);
    period_chk("sh_clear", 3, 7, 0, 0, 0);

    // en dropped mid-period
    period_chk("en_pre", 3, 7, 1, 3, 10);
    step(1, 1); step(1, 1); step(1, 1); step(1, 0); step(1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0);
      check("en_off_valid", bus.meas_valid, 0);
      check("en_off_high", bus.high_cnt, 3);
      check("en_off_period", bus.period_cnt, 10);
      check("en_off_flags", {bus.stuck_high, bus.stuck_low}, 0);
    end
    step(1, 0); step(1, 0);
    period_chk("en_re_first", 3, 7, 0, 0, 0);
    period_chk("en_re", 3, 7, 1, 3, 10);

    // async reset while stuck_low
    step(0, 0);
    repeat (TIMEOUT) step(1, 0);
    check("rst_stuck_pre", bus.stuck_low, 1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    check_zero("async_rst");
    @(negedge clk);
    reset = 1'b1;
    step(1, 0);
    period_chk("p55_first", 5, 5, 0, 0, 0);
    period_chk("p55", 5, 5, 1, 5, 10);
    period_chk("p55b", 5, 5, 1, 5, 10);

    // randomized waveforms, checked by the per-cycle model compare
    for (int seg = 0; seg < 200; seg++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        repeat ($urandom_range(1, 5)) step(0, $urandom_range(0, 1));
      end else if (r == 1) begin
        h = $urandom_range(0, 1);
        repeat ($urandom_range(60, 80)) step(1, h[0]);
      end else if (r == 2) begin
        @(negedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        reset = 1'b1;
      end else begin
        h = $urandom_range(1, 20);
        l = $urandom_range(1, 20);
        n = $urandom_range(1, 4);
        repeat (n) begin
          repeat (h) step(1, 1);
          repeat (l) step(1, 0);
        end
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
